// File: rtl/vs_uart_pkg.sv
// Shared UART-side definitions: ASCII control codes and the hex parser FSM encoding.
package vs_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/vs_ascii_hex_parser_if.sv
// Byte-stream-in / parsed-word-out bundle for vs_ascii_hex_parser.
// Handshake: RX_VALID is a one-cycle strobe qualifying RX_DATA; there is no ready,
// the parser accepts one byte on every cycle RX_VALID is high. VALUE_VALID and ERR
// are one-cycle pulses, VALUE/NDIGITS hold between good frames.
interface vs_ascii_hex_parser_if
    import vs_uart_pkg::*;
#(
    parameter int DIGITS_MAX = 8
);
    localparam int W = 4 * DIGITS_MAX;

    logic [7:0]   RX_DATA;
    logic         RX_VALID;
    logic [W-1:0] VALUE;
    logic         VALUE_VALID;
    logic [3:0]   NDIGITS;
    logic         ERR;
    logic         BUSY;
    state_t       dbg_state;

    // Byte source side (UART receiver / testbench driver)
    modport master (
        output RX_DATA, RX_VALID,
        input  VALUE, VALUE_VALID, NDIGITS, ERR, BUSY, dbg_state
    );

    // Parser side
    modport slave (
        input  RX_DATA, RX_VALID,
        output VALUE, VALUE_VALID, NDIGITS, ERR, BUSY, dbg_state
    );

endinterface

// File: rtl/vs_dc_ascii_hex.sv
// Combinational ASCII -> hex nibble classifier, inverse of the HEX->ASCII table.
// Macro ACCEPT_LOWER_EN: when defined, 'a'-'f' also decode as A-F; otherwise they are illegal.
module vs_dc_ascii_hex
    import vs_uart_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_digit,
    output logic       is_term,
    output logic [3:0] nibble
);

    // Classify the byte; anything not a digit or terminator leaves both flags low
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0] + 4'd9;
`ifdef ACCEPT_LOWER_EN
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0] + 4'd9;
`endif
        end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
            is_term = 1'b1;
        end
    end

endmodule

// File: rtl/vs_ascii_hex_parser.sv
// ASCII hex frame parser: packs hex digits MSB-first, closes a frame on CR/LF,
// rejects illegal bytes and overlong frames. Macro ACCEPT_LOWER_EN (in the decoder)
// enables lowercase hex digits.
module vs_ascii_hex_parser
    import vs_uart_pkg::*;
#(
    parameter int DIGITS_MAX = 8
)(
    input  logic                  CLK,
    input  logic                  RST_N,
    vs_ascii_hex_parser_if.slave  bus
);

    localparam int W = 4 * DIGITS_MAX;

    logic       is_digit;
    logic       is_term;
    logic [3:0] nibble;

    state_t       state_q,       state_d;
    logic [W-1:0] acc_q,         acc_d;
    logic [3:0]   cnt_q,         cnt_d;
    logic [W-1:0] value_q,       value_d;
    logic [3:0]   ndigits_q,     ndigits_d;
    logic         value_valid_q, value_valid_d;
    logic         err_q,         err_d;
    logic         busy_q,        busy_d;

    vs_dc_ascii_hex u_dec (
        .rx_data  (bus.RX_DATA),
        .is_digit (is_digit),
        .is_term  (is_term),
        .nibble   (nibble)
    );

    // Next-state, accumulator and output-register logic; only RX_VALID cycles advance
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        value_d       = value_q;
        ndigits_d     = ndigits_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;
        if (bus.RX_VALID) begin
            unique case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        acc_d   = W'(nibble);
                        cnt_d   = 4'd1;
                        state_d = ACCUM;
                    end else if (!is_term) begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        if (cnt_q == 4'(DIGITS_MAX)) begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            acc_d = {acc_q[W-5:0], nibble};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (is_term) begin
                        value_d       = acc_q;
                        ndigits_d     = cnt_q;
                        value_valid_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            ndigits_q     <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            ndigits_q     <= ndigits_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.VALUE       = value_q;
    assign bus.VALUE_VALID = value_valid_q;
    assign bus.NDIGITS     = ndigits_q;
    assign bus.ERR         = err_q;
    assign bus.BUSY        = busy_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_vs_ascii_hex_parser.sv
// Self-checking bench for vs_ascii_hex_parser: directed frames then random byte stream,
// compared against a frame-level reference model.
module tb_vs_ascii_hex_parser;

    localparam int DIGITS_MAX = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model state: bytes of the currently open frame, last good frame
    logic [7:0]  frame_q[$];
    logic [31:0] m_value;
    logic [31:0] m_ndig;
    logic        exp_vv;
    logic        exp_err;

    vs_ascii_hex_parser_if #(.DIGITS_MAX(DIGITS_MAX)) bus ();

    vs_ascii_hex_parser #(.DIGITS_MAX(DIGITS_MAX)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_is_hex(input logic [7:0] b);
        bit r;
        r = (b >= "0" && b <= "9") || (b >= "A" && b <= "F");
`ifdef ACCEPT_LOWER_EN
        r = r || (b >= "a" && b <= "f");
`endif
        return r;
    endfunction

    function automatic logic [31:0] m_hexval(input logic [7:0] b);
        if (b <= "9") return 32'(b - "0");
        if (b >= "a") return 32'(b - "a" + 10);
        return 32'(b - "A" + 10);
    endfunction

    function automatic bit m_is_term(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    // A frame stays acceptable while it is all hex digits and not too long
    function automatic bit m_frame_ok(input logic [7:0] f[$]);
        if (f.size() > DIGITS_MAX) return 1'b0;
        foreach (f[i]) if (!m_is_hex(f[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic v);
        logic [31:0] acc;
        bit was_ok;
        exp_vv  = 1'b0;
        exp_err = 1'b0;
        if (!v) return;
        if (m_is_term(b)) begin
            if (frame_q.size() > 0 && m_frame_ok(frame_q)) begin
                acc = 0;
                foreach (frame_q[i]) acc = (acc << 4) | m_hexval(frame_q[i]);
                m_value = acc;
                m_ndig  = 32'(frame_q.size());
                exp_vv  = 1'b1;
            end
            frame_q.delete();
        end else begin
            was_ok = m_frame_ok(frame_q);
            frame_q.push_back(b);
            if (was_ok && !m_frame_ok(frame_q)) exp_err = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_value"}, 32'(bus.VALUE), m_value);
        check({tag, "_ndigits"}, 32'(bus.NDIGITS), m_ndig);
        check({tag, "_vvalid"}, 32'(bus.VALUE_VALID), 32'(exp_vv));
        check({tag, "_err"}, 32'(bus.ERR), 32'(exp_err));
        check({tag, "_busy"}, 32'(bus.BUSY), 32'(frame_q.size() > 0));
    endtask

    // Driver: present one byte for one cycle, then check outputs after the edge
    task automatic step(input logic [7:0] b, input logic v, input string tag);
        @(negedge clk);
        bus.RX_DATA  = b;
        bus.RX_VALID = v;
        model_byte(b, v);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, tag);
    endtask

    task automatic idle_cycle(input string tag);
        step(8'h00, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        rst_n = 1'b0;
        #1;
        frame_q.delete();
        m_value = 0;
        m_ndig  = 0;
        exp_vv  = 1'b0;
        exp_err = 1'b0;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic       v;
        int         r;
        string      hexchars;
        checks  = 0;
        errors  = 0;
        m_value = 0;
        m_ndig  = 0;
        exp_vv  = 1'b0;
        exp_err = 1'b0;
        hexchars = "0123456789ABCDEF";
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        // 1: basic frame
        send_str("1A2F\r", "t1");
        check("t1_const", 32'(bus.VALUE), 32'h00001A2F);
        idle_cycle("t1_idle");

        // 2: full-width frame, trailing LF ignored
        send_str("DEADBEEF\r\n", "t2");
        check("t2_const", 32'(bus.VALUE), 32'hDEADBEEF);

        // 3: overflow on 9th digit
        send_str("123456789\r", "t3");
        check("t3_const", 32'(bus.VALUE), 32'hDEADBEEF);

        // 4: illegal char then recovery
        send_str("1G3\n7\n", "t4");
        check("t4_const", 32'(bus.VALUE), 32'h7);

        // 5: lowercase
        send_str("ab\r", "t5");

        // 6: reset mid-frame
        send_str("12", "t6a");
        do_reset("t6_reset");
        send_str("3\r", "t6b");
        check("t6_const", 32'(bus.VALUE), 32'h3);

        // Empty lines and back-to-back frames
        send_str("\r\n\r5\r6\r", "edge");

        // Random byte stream
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            v = 1'b1;
            if (r < 60)      b = hexchars[$urandom_range(0, 15)];
            else if (r < 68) b = 8'(8'h61 + $urandom_range(0, 5));
            else if (r < 80) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            else if (r < 88) b = 8'($urandom_range(0, 255));
            else begin
                b = 8'($urandom_range(0, 255));
                v = 1'b0;
            end
            step(b, v, "rand");
        end
        step(8'h0D, 1'b1, "final");
        idle_cycle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
